ttl_event_scheduler: RTL and testbench

- Timed sequencer for the 32-channel TTL output bank: accepts timestamped {mask, value} events and drives `ttl_out` when a free-running timer reaches each event's timestamp.
- Sits between the AXI command decoder (event/control producer) and the LVDS output buffers.
- Everything runs on the AXI clock domain; output transitions have cycle-accurate timing.

---
 rtl/ttl_event_scheduler_pkg.sv | 36 +++
 rtl/ttl_event_scheduler_if.sv | 40 ++++
 rtl/ttl_event_scheduler_fifo.sv | 77 +++++++
 rtl/ttl_event_scheduler.sv | 116 +++++++++++
 tb/tb_ttl_event_scheduler.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ttl_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package    : ttl_sched_pkg
// Description: Shared widths, event record and scheduler state encoding for
//              the timed TTL event scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
package ttl_sched_pkg;

  // Default widths; the top-level parameters take these as their defaults
  localparam int TIME_WIDTH = 64;
  localparam int TTL_WIDTH  = 32;

  // One queued event: when to fire, which channels, and their new levels
  typedef struct packed {
    logic [TIME_WIDTH-1:0] tstamp;
    logic [TTL_WIDTH-1:0]  mask;
    logic [TTL_WIDTH-1:0]  value;
  } ttl_event_t;

  // Scheduler run state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // Masked merge: channels with mask=1 take the event level, others hold
  function automatic logic [TTL_WIDTH-1:0] apply_event(
    input logic [TTL_WIDTH-1:0] cur,
    input ttl_event_t           ev
  );
    return (cur & ~ev.mask) | (ev.value & ev.mask);
  endfunction

endpackage : ttl_sched_pkg
`default_nettype wire

// File: rtl/ttl_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface  : ttl_event_scheduler_if
// Description: Command-side bundle between the AXI command decoder (master)
//              and the TTL event scheduler (slave): event handshake plus the
//              start/stop/flush/clear_error control pulses.
// Revision   : 1.0 - initial release
// ============================================================================
interface ttl_event_scheduler_if;
  import ttl_sched_pkg::*;

  // Event channel
  logic                  event_valid;
  logic                  event_ready;
  logic [TIME_WIDTH-1:0] event_time;
  logic [TTL_WIDTH-1:0]  event_mask;
  logic [TTL_WIDTH-1:0]  event_value;

  // Control pulses
  logic                  start;
  logic                  stop;
  logic                  flush;
  logic                  clear_error;

  // Command decoder side
  modport master (
    output event_valid, event_time, event_mask, event_value,
    output start, stop, flush, clear_error,
    input  event_ready
  );

  // Scheduler side
  modport slave (
    input  event_valid, event_time, event_mask, event_value,
    input  start, stop, flush, clear_error,
    output event_ready
  );

endinterface : ttl_event_scheduler_if
`default_nettype wire

// File: rtl/ttl_event_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module     : ttl_event_fifo
// Description: Synchronous first-word-fall-through FIFO of ttl_event_t.
//              The head entry is valid combinationally whenever the FIFO is
//              not empty. Flush empties it and discards a same-cycle push.
// Revision   : 1.0 - initial release
// ============================================================================
module ttl_event_fifo
  import ttl_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  input  wire logic   i_push,
  input  ttl_event_t  i_data,
  input  wire logic   i_pop,
  input  wire logic   i_flush,
  output ttl_event_t  o_head,
  output logic        o_empty,
  output logic        o_full,
  output logic [AW:0] o_count
);

  ttl_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push is dropped when full; flush overrides both push and pop
  assign w_push  = i_push && !o_full  && !i_flush;
  assign w_pop   = i_pop  && !o_empty && !i_flush;

  // Storage write; contents need no reset because occupancy gates the head
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : ttl_event_fifo
`default_nettype wire

// File: rtl/ttl_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : ttl_event_scheduler
// Description: Timed sequencer for the TTL output bank. Queues timestamped
//              {mask, value} events and applies each one to ttl_out on the
//              edge that ends the cycle in which the free-running timer has
//              reached the event timestamp (one-cycle output latency).
// Revision   : 1.0 - initial release
// ============================================================================
module ttl_event_scheduler #(
  parameter int TIME_WIDTH = 64,
  parameter int TTL_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  wire logic                  s_axi_aclk,
  input  wire logic                  s_axi_aresetn,
  ttl_event_scheduler_if.slave       evt,
  output logic [TTL_WIDTH-1:0]       ttl_out,
  output logic                       running,
  output logic [TIME_WIDTH-1:0]      timer,
  output logic [FIFO_AW:0]           fifo_count,
  output logic                       late_error
);
  import ttl_sched_pkg::*;

  sched_state_t          r_state;
  logic                  r_running;
  logic [TIME_WIDTH-1:0] r_timer;
  logic [TTL_WIDTH-1:0]  r_ttl;
  logic                  r_late;

  ttl_event_t            w_push_data;
  ttl_event_t            w_head;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_push;
  logic                  w_flush;
  logic                  w_due;
  logic                  w_late;

  // Ready is held low while reset is asserted, otherwise it tracks free space
  assign evt.event_ready = s_axi_aresetn && !w_fifo_full;
  assign w_push          = evt.event_valid && evt.event_ready;
  assign w_push_data     = '{tstamp: evt.event_time,
                             mask:   evt.event_mask,
                             value:  evt.event_value};

  // Flush only takes effect while stopped so a running sequence stays intact
  assign w_flush = evt.flush && (r_state == IDLE);

  // Head is due once the timer has reached it; strictly past means late
  assign w_due   = (r_state == RUN) && !w_fifo_empty && (w_head.tstamp <= r_timer);
  assign w_late  = w_due && (w_head.tstamp < r_timer);

  ttl_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_due),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (fifo_count)
  );

  // Run/idle FSM with the timer; stop has priority over start
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_timer   <= '0;
    end else if (evt.stop) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else if (evt.start) begin
      r_state   <= RUN;
      r_running <= 1'b1;
      r_timer   <= '0;
    end else if (r_state == RUN) begin
      r_timer   <= r_timer + TIME_WIDTH'(1);
    end
  end

  // Output levels: merge the due event into the masked channels
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_ttl <= '0;
    end else if (w_due) begin
      r_ttl <= apply_event(r_ttl, w_head);
    end
  end

  // Sticky late flag; a new late dispatch beats a same-cycle clear
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_late <= 1'b0;
    end else if (w_late) begin
      r_late <= 1'b1;
    end else if (evt.clear_error) begin
      r_late <= 1'b0;
    end
  end

  assign ttl_out    = r_ttl;
  assign running    = r_running;
  assign timer      = r_timer;
  assign late_error = r_late;

endmodule : ttl_event_scheduler
`default_nettype wire

// File: tb/tb_ttl_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : tb_ttl_event_scheduler
// Description: Directed self-checking bench for ttl_event_scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ttl_event_scheduler;

  logic        clk;
  logic        rstn;
  logic [31:0] ttl_out;
  logic        running;
  logic [63:0] timer;
  logic [4:0]  fifo_count;
  logic        late_error;

  int errors = 0;
  int checks = 0;

  ttl_event_scheduler_if bus ();

  ttl_event_scheduler #(
    .TIME_WIDTH (64),
    .TTL_WIDTH  (32),
    .FIFO_DEPTH (16),
    .FIFO_AW    (4)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rstn),
    .evt           (bus),
    .ttl_out       (ttl_out),
    .running       (running),
    .timer         (timer),
    .fifo_count    (fifo_count),
    .late_error    (late_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sampling and driving happen 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.event_valid = 1'b0;
    bus.event_time  = '0;
    bus.event_mask  = '0;
    bus.event_value = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.flush       = 1'b0;
    bus.clear_error = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic push(input logic [63:0] t, input logic [31:0] m, input logic [31:0] v);
    bus.event_valid = 1'b1;
    bus.event_time  = t;
    bus.event_mask  = m;
    bus.event_value = v;
    tick();
    bus.event_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    checks++; if (bus.event_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", bus.event_ready); end
    checks++; if (ttl_out !== 32'h0) begin errors++; $display("FAIL reset_ttl: got %h want 0", ttl_out); end
    checks++; if (timer !== 64'h0) begin errors++; $display("FAIL reset_timer: got %h want 0", timer); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (late_error !== 1'b0) begin errors++; $display("FAIL reset_late: got %b want 0", late_error); end
    rstn = 1'b1;
    #1;
    checks++; if (bus.event_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b want 1", bus.event_ready); end
    tick();
  endtask

  task automatic test_basic_dispatch();
    logic [63:0] k;
    logic        exp_bit;
    do_reset();
    push(64'd10, 32'h1, 32'h1);
    push(64'd20, 32'h1, 32'h0);
    checks++; if (fifo_count !== 5'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", fifo_count); end
    pulse_start();
    k = 64'd0;
    for (int c = 0; c < 30; c++) begin
      exp_bit = (k >= 64'd11) && (k < 64'd21);
      checks++; if (timer !== k) begin errors++; $display("FAIL basic_timer: got %0d want %0d", timer, k); end
      checks++; if (ttl_out[0] !== exp_bit) begin errors++; $display("FAIL basic_ttl0 at k=%0d: got %b want %b", k, ttl_out[0], exp_bit); end
      tick();
      k = k + 64'd1;
    end
    checks++; if (late_error !== 1'b0) begin errors++; $display("FAIL basic_late: got %b want 0", late_error); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL basic_drained: got %0d want 0", fifo_count); end
    pulse_stop();
  endtask

  task automatic test_masked_full();
    do_reset();
    push(64'd0, 32'hFFFF_FFFF, 32'hFFFF_0000);
    pulse_start();
    tick();
    checks++; if (ttl_out !== 32'hFFFF_0000) begin errors++; $display("FAIL preload_ttl: got %h want ffff0000", ttl_out); end
    pulse_stop();
    for (int i = 0; i < 16; i++) begin
      if (i == 0) push(64'd0, 32'h0000_FFFF, 32'h0000_1234);
      else        push(64'd100 + 64'(i), 32'h0, 32'hFFFF_FFFF);
      checks++; if (fifo_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, fifo_count, i + 1); end
      checks++; if (bus.event_ready !== (i < 15)) begin errors++; $display("FAIL fill_ready[%0d]: got %b want %b", i, bus.event_ready, (i < 15)); end
    end
    push(64'd200, 32'hFFFF_FFFF, 32'h0);
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_push_dropped: got %0d want 16", fifo_count); end
    pulse_start();
    tick();
    checks++; if (ttl_out !== 32'hFFFF_1234) begin errors++; $display("FAIL masked_ttl: got %h want ffff1234", ttl_out); end
    checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL masked_count: got %0d want 15", fifo_count); end
    checks++; if (bus.event_ready !== 1'b1) begin errors++; $display("FAIL masked_ready: got %b want 1", bus.event_ready); end
    for (int c = 0; c < 119; c++) tick();
    checks++; if (ttl_out !== 32'hFFFF_1234) begin errors++; $display("FAIL mask0_ttl: got %h want ffff1234", ttl_out); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mask0_drained: got %0d want 0", fifo_count); end
    checks++; if (late_error !== 1'b0) begin errors++; $display("FAIL mask0_late: got %b want 0", late_error); end
    pulse_stop();
  endtask

  task automatic test_equal_ts();
    do_reset();
    push(64'd5, 32'hF, 32'hA);
    push(64'd5, 32'hF, 32'hB);
    pulse_start();
    for (int c = 0; c < 6; c++) tick();
    checks++; if (timer !== 64'd6) begin errors++; $display("FAIL eq_timer6: got %0d want 6", timer); end
    checks++; if (ttl_out !== 32'hA) begin errors++; $display("FAIL eq_ttl_a: got %h want a", ttl_out); end
    checks++; if (late_error !== 1'b0) begin errors++; $display("FAIL eq_late_early: got %b want 0", late_error); end
    tick();
    checks++; if (ttl_out !== 32'hB) begin errors++; $display("FAIL eq_ttl_b: got %h want b", ttl_out); end
    checks++; if (late_error !== 1'b1) begin errors++; $display("FAIL eq_late_set: got %b want 1", late_error); end
    bus.clear_error = 1'b1;
    tick();
    bus.clear_error = 1'b0;
    checks++; if (late_error !== 1'b0) begin errors++; $display("FAIL eq_late_clear: got %b want 0", late_error); end
    pulse_stop();
    // late set and clear on the same edge: set must win
    push(64'd3, 32'hF, 32'h1);
    push(64'd3, 32'hF, 32'h2);
    pulse_start();
    for (int c = 0; c < 4; c++) tick();
    bus.clear_error = 1'b1;
    tick();
    bus.clear_error = 1'b0;
    checks++; if (ttl_out !== 32'h2) begin errors++; $display("FAIL setclr_ttl: got %h want 2", ttl_out); end
    checks++; if (late_error !== 1'b1) begin errors++; $display("FAIL setclr_late: got %b want 1", late_error); end
    pulse_stop();
  endtask

  task automatic test_control();
    do_reset();
    push(64'd12, 32'h1, 32'h1);
    pulse_start();
    for (int c = 0; c < 8; c++) tick();
    checks++; if (timer !== 64'd8) begin errors++; $display("FAIL ctl_timer8: got %0d want 8", timer); end
    pulse_stop();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ctl_stopped: got %b want 0", running); end
    for (int c = 0; c < 10; c++) tick();
    checks++; if (timer !== 64'd8) begin errors++; $display("FAIL ctl_frozen: got %0d want 8", timer); end
    checks++; if (ttl_out !== 32'h0) begin errors++; $display("FAIL ctl_no_dispatch: got %h want 0", ttl_out); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL ctl_pending: got %0d want 1", fifo_count); end
    pulse_start();
    checks++; if (timer !== 64'd0) begin errors++; $display("FAIL ctl_restart: got %0d want 0", timer); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL ctl_running: got %b want 1", running); end
    for (int c = 0; c < 12; c++) tick();
    checks++; if (ttl_out !== 32'h0) begin errors++; $display("FAIL ctl_t12_low: got %h want 0", ttl_out); end
    tick();
    checks++; if (ttl_out !== 32'h1) begin errors++; $display("FAIL ctl_t13_high: got %h want 1", ttl_out); end
    checks++; if (timer !== 64'd13) begin errors++; $display("FAIL ctl_timer13: got %0d want 13", timer); end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ctl_startstop_run: got %b want 0", running); end
    checks++; if (timer !== 64'd13) begin errors++; $display("FAIL ctl_startstop_timer: got %0d want 13", timer); end
    pulse_start();
    push(64'd50, 32'h1, 32'h0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL ctl_flush_run: got %0d want 1", fifo_count); end
    pulse_stop();
    bus.flush       = 1'b1;
    bus.event_valid = 1'b1;
    bus.event_time  = 64'd60;
    bus.event_mask  = 32'h1;
    bus.event_value = 32'h0;
    tick();
    clear_inputs();
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL ctl_flush_idle: got %0d want 0", fifo_count); end
    checks++; if (ttl_out !== 32'h1) begin errors++; $display("FAIL ctl_hold_idle: got %h want 1", ttl_out); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    push(64'd0, 32'hF, 32'h5);
    pulse_start();
    tick();
    push(64'd100, 32'hF, 32'hF);
    push(64'd101, 32'hF, 32'h0);
    push(64'd102, 32'hF, 32'hF);
    checks++; if (ttl_out !== 32'h5) begin errors++; $display("FAIL mid_ttl_before: got %h want 5", ttl_out); end
    checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL mid_count_before: got %0d want 3", fifo_count); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++; if (ttl_out !== 32'h0) begin errors++; $display("FAIL mid_ttl: got %h want 0", ttl_out); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_running: got %b want 0", running); end
    checks++; if (timer !== 64'd0) begin errors++; $display("FAIL mid_timer: got %0d want 0", timer); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_dispatch();
    test_masked_full();
    test_equal_ts();
    test_control();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ttl_event_scheduler
`default_nettype wire
